hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer that drives the PC, IF/ID and ID/EX enables/flushes of the 5-stage core.
//  Resolves load-use, taken-branch, instruction-memory wait and multi-cycle mul/div hazards.
//  Applies one fixed priority each cycle. Sits beside the ID stage; outputs feed pc_reg, IFIDReg and the ID/EX register.
// PARAMETERS
//  MD_LATENCY  8  cycles the mul/div unit occupies EX; front-end frozen for MD_LATENCY-1 cycles after issue
//  LU_STALL    1  bubbles inserted per load-use hazard (1 with forwarding, 2 without); range 1..3
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high
//  id_rs, id_rt     in   5   source register numbers of the instruction in ID
//  id_uses_rs/rt    in   1   ID instruction actually reads rs / rt
//  id_muldiv        in   1   ID instruction is mult/div
//  ex_memread       in   1   EX instruction is a load
//  ex_rd            in   5   destination register of the EX instruction
//  ex_br_taken      in   1   branch/jump resolved taken in EX (redirect this cycle)
//  imem_ready       in   1   instruction memory returns valid data this cycle
//  pc_en            out  1   PC register load enable
//  ifid_en          out  1   IF/ID enable (IF/ID clears only when ifid_en && ifid_flush)
//  ifid_flush       out  1   IF/ID clear request
//  idex_flush       out  1   ID/EX clear (bubble)
//  md_busy          out  1   state == MD_BUSY
// BEHAVIOUR
//  State: RUN, LU_HOLD, MD_BUSY; 2-bit down-counter cnt. Outputs combinational from state+inputs, 0 latency.
//  Reset asserted (async): state=RUN, cnt=0; pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=0, md_busy=0.
//  lu_hit = ex_memread && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
//  Priority, highest first:
//  1 ex_br_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. LU_HOLD->RUN.
//    MD_BUSY keeps counting. id_muldiv ignored (squashed).
//  2 MD_BUSY: pc_en=0, ifid_en=0, idex_flush=1; cnt--. cnt==1 -> RUN next cycle.
//  3 LU_HOLD or lu_hit in RUN: pc_en=0, ifid_en=0, idex_flush=1.
//    On hit in RUN: LU_STALL>1 -> LU_HOLD, cnt=LU_STALL-1.
//    In LU_HOLD: cnt--; cnt==1 -> RUN. No re-compare in LU_HOLD.
//  4 !imem_ready: pc_en=0, ifid_en=1, ifid_flush=1, idex_flush=0 (bubble enters ID; PC holds).
//  5 normal: pc_en=1, ifid_en=1, flushes 0.
//  MD issue: RUN && id_muldiv && !ex_br_taken && !lu_hit.
//    Instruction advances normally this cycle, even when !imem_ready.
//    MD_LATENCY>1 -> MD_BUSY, cnt=MD_LATENCY-1. MD_LATENCY==1 -> stay RUN.
//  cnt width = clog2(max(MD_LATENCY,LU_STALL)); cnt never wraps below 0; cnt is 0 whenever state==RUN.
//  Unlisted outputs default to 0. ifid_flush never asserted with ifid_en=0.
//  Reset mid-stall: immediate return to RUN and reset output values; no residual stall after release.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
//    stall_cycles increments each cycle pc_en==0 && !reset.
//    flush_events increments each cycle ex_br_taken==1.
//    Both cleared by reset; saturate at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent, no other change.
// STRUCTURE
//  Shared package hazard_pkg: state encoding (RUN=0, LU_HOLD=1, MD_BUSY=2), REG_ZERO=5'd0.
//  One sub-module: stall_timer (load/decrement/expire down-counter), used for both LU_HOLD and MD_BUSY.
// TESTING
//  1 ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 (LU_STALL=1):
//    one cycle pc_en=0, ifid_en=0, idex_flush=1, then normal. Same with ex_rd=0: no stall.
//  2 id_muldiv=1 in RUN (MD_LATENCY=8): issue cycle normal; next 7 cycles md_busy=1, pc_en=0, idex_flush=1; cycle 9 RUN.
//  3 ex_br_taken=1 together with lu_hit: all four outputs 1, no stall next cycle.
//    With LU_STALL=2, branch during LU_HOLD returns to RUN.
//  4 imem_ready=0 for 3 cycles: pc_en=0, ifid_en=1, ifid_flush=1 each cycle; idex_flush=0.
//  5 reset pulse (async, off-edge) during MD_BUSY cnt=4: outputs go to reset values immediately; normal from first cycle after release.
//  6 HAZ_PERF_CNT_EN: scenario 2 then one branch -> stall_cycles=7, flush_events=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard sequencer.
//   state_t   : sequencer state encoding (RUN=0, LU_HOLD=1, MD_BUSY=2)
//   REG_ZERO  : hard-wired zero register number (never a real dependency)
//   cnt_width : width of the shared stall down-counter
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_HOLD = 2'd1,
        MD_BUSY = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // clog2(max(md, lu)), never below one bit so the counter always exists.
    function automatic int cnt_width(input int md, input int lu);
        int m;
        int w;
        m = (md > lu) ? md : lu;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stall_timer.sv
// stall_timer: load / decrement / expire down-counter shared by the
// load-use hold and the mul/div busy window.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_clear        : force count to 0 (highest priority)
//   i_load/i_val   : load a new count
//   i_dec          : decrement, saturating at 0
//   o_last         : count is 1, i.e. this decrement ends the window
module stall_timer
    import hazard_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer driving PC, IF/ID and ID/EX enables and
// flushes of the 5-stage core. Resolves taken branch, mul/div occupancy,
// load-use and instruction-memory wait hazards with one fixed priority.
// Outputs are combinational from state and inputs (zero latency).
//   i_clk, i_reset         : clock, asynchronous active-high reset
//   i_id_rs/rt, i_id_uses_rs/rt, i_id_muldiv : ID instruction info
//   i_ex_memread, i_ex_rd, i_ex_br_taken      : EX instruction info
//   i_imem_ready           : instruction memory data valid this cycle
//   o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_md_busy
// Optional: define HAZ_PERF_CNT_EN to add o_stall_cycles / o_flush_events,
// saturating 32-bit counters cleared by reset.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 8,
    parameter int LU_STALL   = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rs,
    input  logic        i_id_uses_rt,
    input  logic        i_id_muldiv,
    input  logic        i_ex_memread,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_br_taken,
    input  logic        i_imem_ready,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_events,
`endif
    output logic        o_pc_en,
    output logic        o_ifid_en,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic        o_md_busy
);

    localparam int               CNT_W   = cnt_width(MD_LATENCY, LU_STALL);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LU_STALL - 1);

    state_t           r_state, w_next;
    logic             w_lu_hit, w_md_issue, w_last;
    logic             w_clear, w_load, w_dec;
    logic [CNT_W-1:0] w_load_val;

    assign w_lu_hit = i_ex_memread && (i_ex_rd != REG_ZERO) &&
                      ((i_id_uses_rs && (i_id_rs == i_ex_rd)) ||
                       (i_id_uses_rt && (i_id_rt == i_ex_rd)));

    assign w_md_issue = (r_state == RUN) && i_id_muldiv &&
                        !i_ex_br_taken && !w_lu_hit;

    stall_timer #(.W(CNT_W)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_reset),
        .i_clear(w_clear),
        .i_load (w_load),
        .i_val  (w_load_val),
        .i_dec  (w_dec),
        .o_last (w_last)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= RUN;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_dec        = 1'b0;
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_md_busy    = (r_state == MD_BUSY);

        if (i_ex_br_taken) begin
            // Redirect squashes IF and ID; an in-flight mul/div keeps running.
            o_pc_en      = 1'b1;
            o_ifid_en    = 1'b1;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            if (r_state == LU_HOLD) begin
                w_next  = RUN;
                w_clear = 1'b1;
            end else if (r_state == MD_BUSY) begin
                w_dec = 1'b1;
                if (w_last) w_next = RUN;
            end
        end else if (r_state == MD_BUSY) begin
            o_idex_flush = 1'b1;
            w_dec        = 1'b1;
            if (w_last) w_next = RUN;
        end else if ((r_state == LU_HOLD) || w_lu_hit) begin
            o_idex_flush = 1'b1;
            if (r_state == LU_HOLD) begin
                // Dependency already known; no re-compare while holding.
                w_dec = 1'b1;
                if (w_last) w_next = RUN;
            end else if (LU_STALL > 1) begin
                w_next     = LU_HOLD;
                w_load     = 1'b1;
                w_load_val = LU_LOAD;
            end
        end else if (w_md_issue) begin
            // The mul/div itself advances into EX even without fresh fetch data.
            o_pc_en   = 1'b1;
            o_ifid_en = 1'b1;
            if (MD_LATENCY > 1) begin
                w_next     = MD_BUSY;
                w_load     = 1'b1;
                w_load_val = MD_LOAD;
            end
        end else if (!i_imem_ready) begin
            // Bubble into ID while the PC waits on fetch.
            o_ifid_en    = 1'b1;
            o_ifid_flush = 1'b1;
        end else begin
            o_pc_en   = 1'b1;
            o_ifid_en = 1'b1;
        end

        if (i_reset) begin
            w_next       = RUN;
            w_clear      = 1'b0;
            w_load       = 1'b0;
            w_dec        = 1'b0;
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_ifid_flush = 1'b0;
            o_idex_flush = 1'b0;
            o_md_busy    = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cycles, r_flush_events;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!o_pc_en && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (i_ex_br_taken && (r_flush_events != 32'hFFFF_FFFF))
                r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench. Each step drives one cycle of inputs and
// pushes the expected {pc_en, ifid_en, ifid_flush, idex_flush, md_busy} for
// two instances (LU_STALL=1 and LU_STALL=2, both MD_LATENCY=8); a negedge
// monitor pops and compares.
module tb_hazard_ctrl;

    localparam logic [4:0] R0 = 5'b00000; // reset / all off
    localparam logic [4:0] N  = 5'b11000; // normal advance
    localparam logic [4:0] ST = 5'b00010; // load-use stall
    localparam logic [4:0] BR = 5'b11110; // taken branch
    localparam logic [4:0] BB = 5'b11111; // taken branch while MD busy
    localparam logic [4:0] IM = 5'b01100; // imem wait
    localparam logic [4:0] MB = 5'b00011; // MD busy

    typedef struct {
        int         id;
        logic [4:0] e1;
        logic [4:0] e2;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       uses_rs, uses_rt, muldiv, memread, br, rdy;
    logic       pc1, ife1, iff1, idf1, mb1;
    logic       pc2, ife2, iff2, idf2, mb2;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stc1, fle1, stc2, fle2;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   sid     = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(8), .LU_STALL(1)) u_dut1 (
        .i_clk(clk), .i_reset(reset),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
        .i_id_muldiv(muldiv), .i_ex_memread(memread), .i_ex_rd(ex_rd),
        .i_ex_br_taken(br), .i_imem_ready(rdy),
`ifdef HAZ_PERF_CNT_EN
        .o_stall_cycles(stc1), .o_flush_events(fle1),
`endif
        .o_pc_en(pc1), .o_ifid_en(ife1), .o_ifid_flush(iff1),
        .o_idex_flush(idf1), .o_md_busy(mb1)
    );

    hazard_ctrl #(.MD_LATENCY(8), .LU_STALL(2)) u_dut2 (
        .i_clk(clk), .i_reset(reset),
        .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
        .i_id_muldiv(muldiv), .i_ex_memread(memread), .i_ex_rd(ex_rd),
        .i_ex_br_taken(br), .i_imem_ready(rdy),
`ifdef HAZ_PERF_CNT_EN
        .o_stall_cycles(stc2), .o_flush_events(fle2),
`endif
        .o_pc_en(pc2), .o_ifid_en(ife2), .o_ifid_flush(iff2),
        .o_idex_flush(idf2), .o_md_busy(mb2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("s%0d.lu1", e.id), {27'd0, pc1, ife1, iff1, idf1, mb1}, {27'd0, e.e1});
            chk($sformatf("s%0d.lu2", e.id), {27'd0, pc2, ife2, iff2, idf2, mb2}, {27'd0, e.e2});
        end
    end

    // Called at posedge+1 with inputs already set; returns at next posedge+1.
    task automatic step(input logic [4:0] e1, input logic [4:0] e2);
        exp_t e;
        e.id = sid;
        e.e1 = e1;
        e.e2 = e2;
        sid++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        uses_rs = 1'b0; uses_rt = 1'b0; muldiv = 1'b0;
        memread = 1'b0; br = 1'b0; rdy = 1'b1;
    endtask

    task automatic lu(input logic [4:0] r);
        memread = 1'b1; ex_rd = r; id_rs = r; uses_rs = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk); #1;
        step(R0, R0);                      // held in reset, inputs request normal
        reset = 1'b0;

        // load-use on rs
        lu(5'd5);               step(ST, ST);
        idle();                 step(N, ST);  // LU_STALL=2 second bubble
        idle();                 step(N, N);
        // same with ex_rd = 0: no dependency
        lu(5'd0);               step(N, N);
        // load-use on rt only
        idle(); memread = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; uses_rt = 1'b1;
                                step(ST, ST);
        idle();                 step(N, ST);
        // matching rs but not used, and matching but not a load
        idle(); memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
                                step(N, N);
        idle(); lu(5'd9); memread = 1'b0;
                                step(N, N);

        // mul/div issue then 7 busy cycles; hazards during busy are masked
        idle(); muldiv = 1'b1;  step(N, N);
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i == 2) begin lu(5'd3); rdy = 1'b0; end
            step(MB, MB);
        end
        idle();                 step(N, N);

        // imem wait for 3 cycles
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 1'b0; step(IM, IM);
        end
        idle();                 step(N, N);

        // branch with load-use: branch wins, no stall after
        idle(); lu(5'd4); br = 1'b1;
                                step(BR, BR);
        idle();                 step(N, N);
        // branch during LU_HOLD returns to RUN
        idle(); lu(5'd6);       step(ST, ST);
        idle(); br = 1'b1;      step(BR, BR);
        idle();                 step(N, N);
        // muldiv squashed by branch / blocked by load-use
        idle(); muldiv = 1'b1; br = 1'b1;
                                step(BR, BR);
        idle();                 step(N, N);
        idle(); muldiv = 1'b1; lu(5'd8);
                                step(ST, ST);
        idle();                 step(N, ST);
        idle();                 step(N, N);

        // branch inside MD_BUSY keeps the countdown going
        idle(); muldiv = 1'b1;  step(N, N);
        idle();                 step(MB, MB);
        idle(); br = 1'b1;      step(BB, BB);
        for (int i = 0; i < 5; i++) begin
            idle(); step(MB, MB);
        end
        idle();                 step(N, N);

        // issue with imem not ready still advances; reset at cnt=4
        idle(); muldiv = 1'b1; rdy = 1'b0;
                                step(N, N);
        for (int i = 0; i < 3; i++) begin
            idle(); step(MB, MB);
        end
        idle(); #1 reset = 1'b1;           // off-edge async reset
        step(R0, R0);
        reset = 1'b0;
        idle();                 step(N, N);

        // mul/div window plus one branch for the perf counters
        idle(); muldiv = 1'b1;  step(N, N);
        for (int i = 0; i < 7; i++) begin
            idle(); step(MB, MB);
        end
        idle(); br = 1'b1;      step(BR, BR);
        idle();                 step(N, N);
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cycles", stc1, 32'd7);
        chk("flush_events", fle1, 32'd1);
`endif

        chk("drain", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
